// File: rtl/ssp_pkg.sv
// rtl/ssp_pkg.sv - shared defaults, width helper and reset constants for the SSP receive FIFO
package ssp_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  localparam logic RST_FLAG = 1'b0;

  // Occupancy must represent 0..DEPTH inclusive, so one bit wider than the pointers
  function automatic int level_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/ssp_rx_timeout.sv
// rtl/ssp_rx_timeout.sv - idle counter raising SSPRTINTR; built only with SSP_RXFIFO_TIMEOUT_EN
module ssp_rx_timeout
  import ssp_pkg::*;
#(
  parameter int TO_CYC = 32
) (
  input  logic PCLK,
  input  logic CLEAR_B,
  input  logic push,
  input  logic pop,
  input  logic rx_empty,
  output logic SSPRTINTR
);

  localparam int CW = $clog2(TO_CYC) + 1;
  localparam logic [CW-1:0] TO_MAX = CW'(TO_CYC);

  logic [CW-1:0] cnt;

  // Any FIFO activity, or nothing left to read, restarts the idle window
  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      cnt <= '0;
    end else if (push || pop || rx_empty) begin
      cnt <= '0;
    end else if (cnt != TO_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign SSPRTINTR = (cnt == TO_MAX) ? ~rx_empty : RST_FLAG;

endmodule

// File: rtl/ssp_rx_fifo_pc.sv
// rtl/ssp_rx_fifo_pc.sv - SSP receive FIFO with level, threshold irq, sticky overrun
// rtl/ssp_rx_fifo_pc.sv - optional receive timeout under SSP_RXFIFO_TIMEOUT_EN
module ssp_rx_fifo_pc
  import ssp_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RX_THRESH = 4,
  parameter int TO_CYC    = 32
) (
  input  logic                          PCLK,
  input  logic                          CLEAR_B,
  input  logic                          PSEL,
  input  logic                          PWRITE,
  input  logic                          write_cmd,
  input  logic [DATA_W-1:0]             RxData,
  input  logic                          rx_ovr_clr,
  output logic [DATA_W-1:0]             PRDATA,
  output logic [level_w(ADDR_W)-1:0]    rx_level,
  output logic                          rx_empty,
  output logic                          rx_full,
  output logic                          SSPRXINTR,
  output logic                          rx_overrun,
  output logic                          SSPRTINTR
);

  localparam int LW    = level_w(ADDR_W);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] THR_LVL  = LW'(RX_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [LW-1:0]     level_r;
  logic              ovr_r;
  logic              push;
  logic              pop;
  logic              ovr_set;

  assign rx_empty   = (level_r == '0);
  assign rx_full    = (level_r == FULL_LVL);
  assign SSPRXINTR  = (level_r >= THR_LVL);
  assign rx_level   = level_r;
  assign rx_overrun = ovr_r;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it
  assign pop     = PSEL & ~PWRITE & ~rx_empty;
  assign push    = write_cmd & (~rx_full | pop);
  assign ovr_set = write_cmd & rx_full & ~pop;

  assign PRDATA = pop ? mem[rd_ptr] : '0;

  always_ff @(posedge PCLK) begin
    if (push) begin
      mem[wr_ptr] <= RxData;
    end
  end

  always_ff @(posedge PCLK) begin
    if (!CLEAR_B) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_r <= '0;
      ovr_r   <= RST_FLAG;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
      // Set has priority over a simultaneous clear
      if (ovr_set)         ovr_r <= 1'b1;
      else if (rx_ovr_clr) ovr_r <= 1'b0;
    end
  end

`ifdef SSP_RXFIFO_TIMEOUT_EN
  ssp_rx_timeout #(
    .TO_CYC(TO_CYC)
  ) u_timeout (
    .PCLK      (PCLK),
    .CLEAR_B   (CLEAR_B),
    .push      (push),
    .pop       (pop),
    .rx_empty  (rx_empty),
    .SSPRTINTR (SSPRTINTR)
  );
`else
  assign SSPRTINTR = RST_FLAG & (TO_CYC > 0);
`endif

endmodule
